// File: rtl/blinds_motor_controller.sv
// Blinds motor driver: runs the motor toward the commanded end stop with a
// motor-off dead time before every start, and latches travel/limit faults.
module blinds_motor_controller #(
  parameter int TRAVEL_CYCLES   = 1000,
  parameter int DEADTIME_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic blinds_open,
  input  logic limit_open,
  input  logic limit_closed,
  input  logic fault_clear,
  output logic motor_up,
  output logic motor_down,
  output logic moving,
  output logic at_open,
  output logic at_closed,
  output logic fault
);

  typedef enum logic [2:0] {
    IDLE,
    DEADTIME,
    RAISING,
    LOWERING,
    FAULT
  } state_t;

  localparam logic [CNT_W-1:0] DEAD_LAST   = CNT_W'(DEADTIME_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);

  state_t           state;
  logic             dir;
  logic [CNT_W-1:0] cnt;

  // Outputs default low each edge and are set only on edges that land in
  // (or stay in) the matching state, so they always equal a decode of state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dir        <= 1'b0;
      cnt        <= '0;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      moving     <= 1'b0;
      fault      <= 1'b0;
      at_open    <= 1'b0;
      at_closed  <= 1'b0;
    end else begin
      at_open    <= limit_open & ~limit_closed;
      at_closed  <= limit_closed & ~limit_open;
      motor_up   <= 1'b0;
      motor_down <= 1'b0;
      moving     <= 1'b0;
      fault      <= 1'b0;

      if (state != FAULT && limit_open && limit_closed) begin
        state <= FAULT;
        fault <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (blinds_open && !limit_open) begin
              state <= DEADTIME;
              dir   <= 1'b1;
              cnt   <= '0;
            end else if (!blinds_open && !limit_closed) begin
              state <= DEADTIME;
              dir   <= 1'b0;
              cnt   <= '0;
            end
          end

          DEADTIME: begin
            if (blinds_open != dir) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == DEAD_LAST) begin
              state      <= dir ? RAISING : LOWERING;
              cnt        <= '0;
              motor_up   <= dir;
              motor_down <= ~dir;
              moving     <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          RAISING: begin
            if (limit_open) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (!blinds_open) begin
              state <= DEADTIME;
              dir   <= 1'b0;
              cnt   <= '0;
            end else if (cnt == TRAVEL_LAST) begin
              state <= FAULT;
              cnt   <= '0;
              fault <= 1'b1;
            end else begin
              cnt      <= cnt + CNT_W'(1);
              motor_up <= 1'b1;
              moving   <= 1'b1;
            end
          end

          LOWERING: begin
            if (limit_closed) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (blinds_open) begin
              state <= DEADTIME;
              dir   <= 1'b1;
              cnt   <= '0;
            end else if (cnt == TRAVEL_LAST) begin
              state <= FAULT;
              cnt   <= '0;
              fault <= 1'b1;
            end else begin
              cnt        <= cnt + CNT_W'(1);
              motor_down <= 1'b1;
              moving     <= 1'b1;
            end
          end

          FAULT: begin
            if (fault_clear) begin
              state <= IDLE;
              cnt   <= '0;
            end else begin
              fault <= 1'b1;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_blinds_motor_controller.sv
// Bench for blinds_motor_controller: directed scenarios plus a randomized run
// against a simple plant, all compared with a behavioural model every cycle.
module tb_blinds_motor_controller;

  localparam int TRAVEL = 20;
  localparam int DEAD   = 4;
  localparam int SPAN   = 24;

  logic clk = 1'b0;
  logic rst, blinds_open, limit_open, limit_closed, fault_clear;
  logic motor_up, motor_down, moving, at_open, at_closed, fault;

  int passCount = 0;
  int checkCount = 0;

  // Model: faulted flag, pending dead-time progress (-1 = none), and the
  // running direction (+1 up, -1 down, 0 off) with cycles spent running.
  bit m_faulted = 1'b0;
  int m_pending = -1;
  bit m_pend_up = 1'b0;
  int m_run     = 0;
  int m_run_len = 0;
  bit e_at_open = 1'b0;
  bit e_at_closed = 1'b0;

  blinds_motor_controller #(
    .TRAVEL_CYCLES(TRAVEL),
    .DEADTIME_CYCLES(DEAD),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .blinds_open(blinds_open),
    .limit_open(limit_open),
    .limit_closed(limit_closed),
    .fault_clear(fault_clear),
    .motor_up(motor_up),
    .motor_down(motor_down),
    .moving(moving),
    .at_open(at_open),
    .at_closed(at_closed),
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
  endtask

  task automatic modelStep(input bit bo, input bit lo, input bit lc, input bit fc, input bit r);
    if (r) begin
      m_faulted = 0; m_pending = -1; m_run = 0; m_run_len = 0;
      e_at_open = 0; e_at_closed = 0;
    end else begin
      e_at_open   = lo && !lc;
      e_at_closed = lc && !lo;
      if (m_faulted) begin
        if (fc) m_faulted = 0;
      end else if (lo && lc) begin
        m_faulted = 1; m_pending = -1; m_run = 0;
      end else if (m_run != 0) begin
        if ((m_run > 0 && lo) || (m_run < 0 && lc)) m_run = 0;
        else if ((m_run > 0) != bo) begin
          m_run = 0; m_pending = 0; m_pend_up = bo;
        end else if (m_run_len == TRAVEL) begin
          m_run = 0; m_faulted = 1;
        end else m_run_len++;
      end else if (m_pending >= 0) begin
        if (bo != m_pend_up) m_pending = -1;
        else begin
          m_pending++;
          if (m_pending == DEAD) begin
            m_pending = -1; m_run = m_pend_up ? 1 : -1; m_run_len = 1;
          end
        end
      end else if (bo && !lo) begin
        m_pending = 0; m_pend_up = 1;
      end else if (!bo && !lc) begin
        m_pending = 0; m_pend_up = 0;
      end
    end
  endtask

  task automatic compareAll();
    checkOutput("motor_up",   int'(motor_up),   int'(m_run > 0));
    checkOutput("motor_down", int'(motor_down), int'(m_run < 0));
    checkOutput("moving",     int'(moving),     int'(m_run != 0));
    checkOutput("fault",      int'(fault),      int'(m_faulted));
    checkOutput("at_open",    int'(at_open),    int'(e_at_open));
    checkOutput("at_closed",  int'(at_closed),  int'(e_at_closed));
    checkOutput("no_overlap", int'(motor_up & motor_down), 0);
  endtask

  // Drive at the falling edge, let the DUT and model see the same rising
  // edge, then compare just after it.
  task automatic applyStimulus(input bit bo, input bit lo, input bit lc, input bit fc, input bit r);
    @(negedge clk);
    blinds_open = bo; limit_open = lo; limit_closed = lc; fault_clear = fc; rst = r;
    @(posedge clk);
    modelStep(bo, lo, lc, fc, r);
    #1;
    compareAll();
  endtask

  int upCount;
  int pos;
  bit bo, lo, lc, fc, r;

  initial begin
    rst = 1; blinds_open = 0; limit_open = 0; limit_closed = 0; fault_clear = 0;
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("reset_up", int'(motor_up), 0);

    // Open command: motor rises DEAD edges after the command edge.
    for (int i = 0; i < DEAD; i++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("up_early", int'(motor_up), 0);
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("up_start", int'(motor_up), 1);
    for (int i = 0; i < 9; i++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("up_stop", int'(motor_up), 0);
    checkOutput("at_open_set", int'(at_open), 1);

    // Raise again, then reverse mid-travel.
    for (int i = 0; i < 8; i++) applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rev_up_drop", int'(motor_up), 0);
    for (int i = 0; i < DEAD - 1; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rev_down_wait", int'(motor_down), 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rev_down_start", int'(motor_down), 1);

    // Timeout while raising with no limit.
    upCount = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1, 0, 0, 0, 0);
      if (motor_up) upCount++;
    end
    checkOutput("timeout_len", upCount, TRAVEL);
    checkOutput("timeout_fault", int'(fault), 1);
    for (int i = 0; i < 6; i++) applyStimulus(i[0], 0, 0, 0, 0);
    checkOutput("fault_held", int'(fault), 1);
    applyStimulus(1, 0, 0, 1, 0);
    checkOutput("fault_cleared", int'(fault), 0);
    for (int i = 0; i < DEAD + 1; i++) applyStimulus(1, 0, 0, 0, 0);
    checkOutput("restart_up", int'(motor_up), 1);

    // Contradictory limits while lowering.
    for (int i = 0; i < DEAD + 3; i++) applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);
    checkOutput("both_fault", int'(fault), 1);
    checkOutput("both_down", int'(motor_down), 0);
    applyStimulus(0, 0, 0, 1, 0);

    // Reset on the seventh lowering cycle.
    for (int i = 0; i < DEAD + 1 + 6; i++) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pre_rst_down", int'(motor_down), 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("rst_down", int'(motor_down), 0);
    checkOutput("rst_fault", int'(fault), 0);

    // Direction change inside the dead time.
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    upCount = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(0, 0, 0, 0, 0);
      if (motor_up) upCount++;
    end
    checkOutput("toggle_no_up", upCount, 0);
    checkOutput("toggle_down", int'(motor_down), 1);

    // Randomized run against a plant whose limits follow the motor.
    pos = SPAN / 2;
    bo = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) bo = ~bo;
      lo = (pos >= SPAN);
      lc = (pos <= 0);
      if ($urandom_range(0, 199) == 0) begin lo = 1; lc = 1; end
      fc = ($urandom_range(0, 19) == 0);
      r  = ($urandom_range(0, 499) == 0);
      applyStimulus(bo, lo, lc, fc, r);
      pos += m_run;
      if (pos < 0) pos = 0;
      if (pos > SPAN) pos = SPAN;
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
